// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default widths, PC step and opcode field layout
// used by the fetch stage and the decoder.
package cpu_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_INSTR_W = 32;
   localparam int PC_STEP     = 4;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 24;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   typedef enum logic [OPC_W-1:0] {
      OPC_NOP    = 8'h00,
      OPC_ALU    = 8'h01,
      OPC_ALUI   = 8'h02,
      OPC_LOAD   = 8'h10,
      OPC_STORE  = 8'h11,
      OPC_BRANCH = 8'h20,
      OPC_JUMP   = 8'h21
   } opcode_e;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [DEF_INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs with a single-cycle flush.
// Push and pop may coincide at any occupancy, including full.
module fetch_fifo #(
   parameter int DEPTH   = 2,
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic [ADDR_W-1:0]  push_pc_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   input  logic               pop_i,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic               empty_o,
   output logic [CNT_W-1:0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign empty_o      = (count_q == '0);
   assign full         = (count_q == CNT_W'(DEPTH));
   assign count_o      = count_q;
   assign head_pc_o    = pc_mem_q[rd_ptr_q];
   assign head_instr_o = instr_mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         pc_mem_q[wr_ptr_q]    <= push_pc_i;
         instr_mem_q[wr_ptr_q] <= push_instr_i;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, response FIFO and redirect flush.
// Optional FETCH_PERF_EN adds a saturating stall_cycles counter output.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        stall_cycles
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  discard_q, discard_d;
   logic              init_q;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [CNT_W:0]    occupancy;
   logic              req_hs, push, pop;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              unused_redirect_lsb;

   assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Outstanding requests plus buffered words never exceed DEPTH, so a push always finds room.
   always_comb begin
      occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count};
      imem_req_valid = !rst && !init_q && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
      imem_req_addr  = fetch_pc_q;
      req_hs         = imem_req_valid && imem_req_ready;
      out_valid      = !rst && !fifo_empty;
      pop            = out_valid && out_ready && !redirect_valid;
      push           = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      discard_d  = discard_q;
      inflight_d = inflight_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_aligned;
         rsp_pc_d   = redirect_aligned;
         // Everything still outstanding after this cycle belongs to the abandoned path.
         discard_d  = inflight_d;
      end else begin
         if (req_hs) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
         if (imem_rsp_valid) begin
            if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
            else                 rsp_pc_d  = rsp_pc_q + ADDR_W'(PC_STEP);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         init_q     <= 1'b1;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         init_q     <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect_valid),
      .push_i       (push),
      .push_pc_i    (rsp_pc_q),
      .push_instr_i (imem_rsp_data),
      .pop_i        (pop),
      .head_pc_o    (out_pc),
      .head_instr_o (out_instr),
      .empty_o      (fifo_empty),
      .count_o      (fifo_count)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (out_ready && !out_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
// Build with FETCH_PERF_EN defined to also exercise stall_cycles.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles;
`endif

   int total = 0;
   int bad   = 0;
   int lat   = 1;
   int req_cnt = 0;
   logic [31:0] got_pc[$];
   logic [31:0] got_in[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: every accepted request returns exactly lat cycles later, in order.
   logic [7:0]  pv;
   logic [31:0] pa [8];
   always @(posedge clk) begin
      if (rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[6:0], imem_req_valid && imem_req_ready};
         pa[0] <= imem_req_addr;
         for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
      end
   end
   assign imem_rsp_valid = pv[lat-1];
   assign imem_rsp_data  = instr_of(pa[lat-1]);

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !redirect_valid) begin
         got_pc.push_back(out_pc);
         got_in.push_back(out_instr);
      end
      if (!rst && imem_req_valid && imem_req_ready) req_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      got_pc.delete();
      got_in.delete();
      req_cnt = 0;
   endtask

   task automatic wait_got(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (got_pc.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      lat = 1; out_ready = 1'b1; rst = 1'b1; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
      tick();
      rst = 1'b0; #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL post_rst_req_valid got=%b want=0", imem_req_valid); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b want=0", out_valid); end
      tick();
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b want=1", imem_req_valid); end
      total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_req_addr got=%h want=00000000", imem_req_addr); end
   endtask

   task automatic test_stream();
      bit ok;
      lat = 1; out_ready = 1'b1;
      do_reset();
      wait_got(3, ok);
      total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d want=3", got_pc.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (got_pc[i] !== 32'(4*i) || got_in[i] !== instr_of(32'(4*i))) begin
               bad++; $display("FAIL stream_%0d got=%h/%h want=%h/%h", i, got_pc[i], got_in[i], 32'(4*i), instr_of(32'(4*i)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      lat = 1; out_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      total++; if (req_cnt !== 2) begin bad++; $display("FAIL bp_req_count got=%0d want=2", req_cnt); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b want=0", imem_req_valid); end
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%b/%h want=1/00000000", out_valid, out_pc); end
      repeat (3) tick();
      total++; if (out_pc !== 32'h0 || out_instr !== instr_of(32'h0)) begin bad++; $display("FAIL bp_hold got=%h/%h want=00000000/%h", out_pc, out_instr, instr_of(32'h0)); end
      out_ready = 1'b1;
      wait_got(3, ok);
      total++;
      if (!ok || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8) begin
         bad++; $display("FAIL bp_release got_n=%0d want=00000000,00000004,00000008", got_pc.size());
      end
   endtask

   task automatic test_redirect();
      bit ok;
      lat = 3; out_ready = 1'b1;
      do_reset();
      tick(); tick(); tick();
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_credit_full got=%b want=0", imem_req_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_req_in_redirect got=%b want=0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_out_after got=%b want=0", out_valid); end
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (imem_req_valid) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (!ok || imem_req_addr !== 32'h100) begin bad++; $display("FAIL rd_next_req got=%b/%h want=1/00000100", ok, imem_req_addr); end
      wait_got(1, ok);
      total++;
      if (!ok || got_pc[0] !== 32'h100 || got_in[0] !== instr_of(32'h100)) begin
         bad++; $display("FAIL rd_first_out got_n=%0d want=00000100", got_pc.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      lat = 3; out_ready = 1'b0;
      do_reset();
      tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect_pc = 32'h0000_0301;
      tick();
      redirect_valid = 1'b0; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_out_after got=%b want=0", out_valid); end
      out_ready = 1'b1;
      wait_got(2, ok);
      total++;
      if (!ok || got_pc[0] !== 32'h300 || got_in[0] !== instr_of(32'h300) || got_pc[1] !== 32'h304) begin
         bad++; $display("FAIL b2b_seq got_n=%0d want=00000300,00000304", got_pc.size());
      end
   endtask

   task automatic test_wrap();
      bit ok;
      lat = 1; out_ready = 1'b1;
      do_reset();
      repeat (4) tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      got_pc.delete(); got_in.delete();
      tick();
      redirect_valid = 1'b0;
      wait_got(3, ok);
      total++;
      if (!ok || got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0 || got_pc[2] !== 32'h4) begin
         bad++; $display("FAIL wrap_seq got_n=%0d want=fffffffc,00000000,00000004", got_pc.size());
      end
      else begin
         total++; if (got_in[1] !== instr_of(32'h0)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", got_in[1], instr_of(32'h0)); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      lat = 1; out_ready = 1'b1;
      do_reset();
      repeat (6) tick();
      out_ready = 1'b0;
      repeat (6) tick();
      total++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rm_full got=%b/%b want=1/0", out_valid, imem_req_valid); end
      rst = 1'b1; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_during got=%b want=0", out_valid); end
      tick();
      rst = 1'b0; #1;
      total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rm_after got=%b/%b want=0/0", out_valid, imem_req_valid); end
      got_pc.delete(); got_in.delete();
      out_ready = 1'b1;
      wait_got(2, ok);
      total++;
      if (!ok || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
         bad++; $display("FAIL rm_refetch got_n=%0d want=00000000,00000004", got_pc.size());
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      int exp_stall;
      bit ok;
      lat = 3; out_ready = 1'b1;
      rst = 1'b1; tick();
      rst = 1'b0; #1;
      exp_stall = 0;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin ok = 1'b1; break; end
         exp_stall++;
         tick();
      end
      total++;
      if (!ok || stall_cycles !== 32'(exp_stall)) begin
         bad++; $display("FAIL perf_stall got=%0d want=%0d", stall_cycles, exp_stall);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
